// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - two-stage normalize and round-to-nearest-even for raw FP results
// Stage 1 finds the leading one; stage 2 shifts, rounds, and resolves overflow/underflow.

module leading_one_detector #(
  parameter int W  = 27,
  parameter int PW = $clog2(W)
) (
  input  logic [W-1:0]  mant,
  output logic [PW-1:0] pos
);
  // Ascending scan so the highest set bit wins.
  always_comb begin
    pos = '0;
    for (int i = 0; i < W; i++) begin
      if (mant[i]) pos = PW'(i);
    end
  end
endmodule

module fp_normalize_round #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sign,
  input  logic [EXP_WIDTH-1:0]         in_exp,
  input  logic [MAN_WIDTH+3:0]         in_mant,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0] out_result,
  output logic                         out_overflow,
  output logic                         out_underflow,
  output logic                         out_inexact
);
  localparam int W   = MAN_WIDTH + 4;
  localparam int PW  = $clog2(W);
  localparam int EW2 = EXP_WIDTH + 2;
  localparam logic signed [EW2-1:0] EXP_MAX = EW2'((1 << EXP_WIDTH) - 1);
  localparam logic signed [EW2-1:0] EXP_ONE = EW2'(1);

  logic                 s1_valid;
  logic                 s1_sign;
  logic [EXP_WIDTH-1:0] s1_exp;
  logic [W-1:0]         s1_mant;
  logic [PW-1:0]        s1_pos;
  logic                 s1_zero;
  logic [PW-1:0]        lod_pos;

  logic e1, e2;
  assign e2       = !out_valid | out_ready;
  assign e1       = !s1_valid | e2;
  assign in_ready = rst_n & e1;

  leading_one_detector #(.W(W), .PW(PW)) u_lod (
    .mant (in_mant),
    .pos  (lod_pos)
  );

  logic [W-1:0]            norm;
  logic [PW-1:0]           shamt;
  logic signed [EW2-1:0]   exp_n;
  logic signed [EW2-1:0]   exp_f;
  logic [MAN_WIDTH+1:0]    sig_r;
  logic                    inc;

  // Normalize to hidden bit at W-2, then RNE on guard/sticky with carry-out renormalization.
  always_comb begin
    shamt = PW'(W - 2) - s1_pos;
    exp_n = $signed({2'b00, s1_exp});
    norm  = s1_mant;
    if (s1_pos == PW'(W - 1)) begin
      norm  = {1'b0, s1_mant[W-1:2], s1_mant[1] | s1_mant[0]};
      exp_n = exp_n + EW2'(1);
    end else if (s1_pos < PW'(W - 2)) begin
      norm  = s1_mant << shamt;
      exp_n = exp_n - $signed(EW2'(shamt));
    end
    inc   = norm[1] & (norm[0] | norm[2]);
    sig_r = {1'b0, norm[W-2:2]} + {{(MAN_WIDTH+1){1'b0}}, inc};
    exp_f = sig_r[MAN_WIDTH+1] ? exp_n + EW2'(1) : exp_n;
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, norm[W-1], sig_r[MAN_WIDTH]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else begin
      if (e1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign <= in_sign;
          s1_exp  <= in_exp;
          s1_mant <= in_mant;
          s1_pos  <= lod_pos;
          s1_zero <= (in_mant == '0);
        end
      end
      if (e2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          if (s1_zero) begin
            out_result    <= {s1_sign, {(EXP_WIDTH+MAN_WIDTH){1'b0}}};
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
          end else if (exp_f >= EXP_MAX) begin
            out_result    <= {s1_sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
            out_overflow  <= 1'b1;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b1;
          end else if (exp_f < EXP_ONE) begin
            out_result    <= {s1_sign, {(EXP_WIDTH+MAN_WIDTH){1'b0}}};
            out_overflow  <= 1'b0;
            out_underflow <= 1'b1;
            out_inexact   <= 1'b1;
          end else begin
            out_result    <= {s1_sign, exp_f[EXP_WIDTH-1:0], sig_r[MAN_WIDTH-1:0]};
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= norm[1] | norm[0];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_fp_normalize_round.sv
// tb/tb_fp_normalize_round.sv - self-checking bench for fp_normalize_round (E=8, M=23)
// Reference model rounds the raw mantissa numerically to 24 significant bits.

module tb_fp_normalize_round;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [26:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_overflow, out_underflow, out_inexact;
  logic [34:0] obs;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign obs = {out_overflow, out_underflow, out_inexact, out_result};

  fp_normalize_round #(.EXP_WIDTH(8), .MAN_WIDTH(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
  );

  // Value = mant * 2^(exp-25); keep 24 significant bits, round half to even.
  function automatic logic [34:0] ref_model(input bit s, input int e, input longint m);
    int p, d, ef;
    longint q, rem, half;
    bit inx;
    if (m == 0) return {3'b000, s, 31'b0};
    p = 0;
    for (int i = 0; i < 27; i++) if (m[i]) p = i;
    d = p - 23;
    inx = 1'b0;
    if (d > 0) begin
      q    = m >> d;
      rem  = m & ((64'(1) << d) - 1);
      half = 64'(1) << (d - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end else begin
      q = m << (-d);
    end
    ef = e + p - 25;
    if (q == (64'(1) << 24)) begin
      q  = 64'(1) << 23;
      ef = ef + 1;
    end
    if (ef >= 255) return {3'b101, s, 8'hFF, 23'b0};
    if (ef <= 0) return {3'b011, s, 31'b0};
    return {2'b00, inx, s, ef[7:0], q[22:0]};
  endfunction

  task automatic gen_op();
    logic [26:0] r;
    r = 27'($urandom);
    in_sign = 1'($urandom);
    in_exp  = ($urandom_range(1) == 1) ? 8'($urandom_range(160, 100)) : 8'($urandom);
    case ($urandom_range(4))
      0: in_mant = '0;
      1: in_mant = r;
      2: in_mant = r | 27'h4000000;
      3: in_mant = r >> $urandom_range(26);
      default: in_mant = (r & 27'h1FFFFFF) | 27'h2000000;
    endcase
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++;
    if (obs !== 35'h0) begin n_fail++; $display("FAIL reset_result_flags: got %h expected 0", obs); end
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_vectors();
    bit          vs[9] = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
    logic [7:0]  ve[9] = '{127, 127, 127, 127, 127, 254, 1, 200, 127};
    logic [26:0] vm[9] = '{27'h2000000, 27'h4000000, 27'h0000004, 27'h2000006, 27'h2000002,
                           27'h4000000, 27'h1000000, 27'h0000000, 27'h3FFFFFE};
    logic [34:0] vx[9] = '{{3'b000, 32'h3F800000}, {3'b000, 32'h40000000}, {3'b000, 32'h34000000},
                           {3'b001, 32'h3F800002}, {3'b001, 32'h3F800000}, {3'b101, 32'h7F800000},
                           {3'b011, 32'h80000000}, {3'b000, 32'h80000000}, {3'b001, 32'h40000000}};
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sign = vs[k]; in_exp = ve[k]; in_mant = vm[k]; out_ready = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL vec%0d_in_ready: got %b expected 1", k, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL vec%0d_early_valid: got %b expected 0", k, out_valid); end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || obs !== vx[k]) begin
        n_fail++;
        $display("FAIL vec%0d_result: got valid=%b %h expected valid=1 %h", k, out_valid, obs, vx[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [34:0] exp_q[$];
    int          acc_q[$];
    logic [34:0] e;
    int          a;
    int          sent = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 1000 && (sent < 200 || exp_q.size() > 0); cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_unexpected: got %h expected no output", obs);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          if (obs !== e || cyc != a + 2) begin
            n_fail++;
            $display("FAIL rand_result: got %h at cycle %0d expected %h at cycle %0d", obs, cyc, e, a + 2);
          end
        end
      end
      if (sent < 200 && $urandom_range(3) != 0) begin
        in_valid = 1'b1;
        gen_op();
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(in_sign, int'(in_exp), longint'(in_mant)));
        acc_q.push_back(cyc);
        sent++;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (sent != 200 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_timeout: got sent=%0d pending=%0d expected 200/0", sent, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [34:0] exp_q[$];
    logic [34:0] e, prev_obs;
    bit          prev_stall = 1'b0;
    int          occ = 0, sent = 0, got = 0;
    bit          exp_ready;
    prev_obs = '0;
    for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== prev_obs) begin
          n_fail++; $display("FAIL b2b_stall_hold: got valid=%b %h expected valid=1 %h", out_valid, obs, prev_obs);
        end
      end
      in_valid = (sent < 8);
      if (sent < 8) gen_op();
      out_ready = 1'($urandom_range(1));
      #1;
      exp_ready = !(occ == 2 && !out_ready);
      n_cmp++;
      if (in_ready !== exp_ready) begin
        n_fail++; $display("FAIL b2b_in_ready: got %b expected %b (occupancy %0d)", in_ready, exp_ready, occ);
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected: got %h expected no output", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin n_fail++; $display("FAIL b2b_order: got %h expected %h", obs, e); end
        end
        got++;
        occ--;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(in_sign, int'(in_exp), longint'(in_mant)));
        sent++;
        occ++;
      end
      prev_stall = out_valid && !out_ready;
      prev_obs = obs;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (got != 8) begin n_fail++; $display("FAIL b2b_timeout: got %0d results expected 8", got); end
  endtask

  task automatic test_reset_flight();
    logic [34:0] e;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_mant = 27'h2000000;
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'd130; in_mant = 27'h4000000;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flight_in_ready_rst: got %b expected 0", in_ready); end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flight_valid_after_rst: got %b expected 0", out_valid); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flight_ghost%0d: got valid=%b %h expected 0", i, out_valid, obs); end
    end
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd100; in_mant = 27'h2C00001;
    e = ref_model(1'b0, 100, 64'h2C00001);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flight_post_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flight_post_early: got %b expected 0", out_valid); end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || obs !== e) begin
      n_fail++; $display("FAIL flight_post_result: got valid=%b %h expected valid=1 %h", out_valid, obs, e);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_reset_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
